alarm_scheduler: RTL and testbench

Alarm controller that sits beside the 24-hour clock core and sequences a single wake-up alarm against its running time. It holds a user-set alarm time, detects the match, runs a ring/snooze/stop state machine, and arbitrates the shared buzzer and LED between the alarm and the clock core's hourly chime. All logic runs on the 1 Hz timing clock, so one cycle equals one second.

---
 rtl/alarm_pkg.sv | 41 ++++
 rtl/alarm_scheduler_if.sv | 49 ++++
 rtl/alarm_time_reg.sv | 50 +++++
 rtl/alarm_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_alarm_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm scheduler slice: state encoding, set-mode
// encoding, hour/minute wrap limits and small helpers for the stored alarm time.
// Optional feature macro used by the slice: ALARM_SNOOZE_EN.
// -----------------------------------------------------------------------------
package alarm_pkg;

  // Alarm sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_e;

  // Alarm-time edit modes selected by the set button.
  typedef enum logic [1:0] {
    SET_NONE = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } set_mode_e;

  localparam logic [7:0] HOUR_MAX = 8'd23;
  localparam logic [7:0] MIN_MAX  = 8'd59;

  // Increment with wrap to zero once the limit is reached.
  function automatic logic [7:0] wrap_inc(input logic [7:0] value,
                                          input logic [7:0] max);
    return (value >= max) ? 8'd0 : value + 8'd1;
  endfunction

  // Set button walks NONE -> HOUR -> MIN -> NONE.
  function automatic set_mode_e next_set_mode(input set_mode_e mode);
    case (mode)
      SET_NONE: return SET_HOUR;
      SET_HOUR: return SET_MIN;
      default:  return SET_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alarm_scheduler_if.sv
// -----------------------------------------------------------------------------
// alarm_scheduler_if
// Bundles the clock-core time, user buttons and alarm outputs of the alarm
// scheduler. The master side (clock core / UI) drives time and buttons; the
// slave side (alarm_scheduler) drives the stored alarm time and the outputs.
//   hours/minutes/seconds : running time, 8 bits each
//   chime_in              : hourly chime from the clock core
//   alm_on                : alarm enable level
//   set_alm/inc/snooze/stop : one-cycle button pulses
//   alm_hours/alm_minutes : stored alarm time
//   alm_set_mode          : 0 none, 1 set hour, 2 set minute
//   ringing/snoozing/buzzer/led : alarm status and shared indicator drives
// Optional feature macro affecting the slave: ALARM_SNOOZE_EN.
// -----------------------------------------------------------------------------
interface alarm_scheduler_if;

  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic       chime_in;
  logic       alm_on;
  logic       set_alm;
  logic       inc;
  logic       snooze;
  logic       stop;

  logic [7:0] alm_hours;
  logic [7:0] alm_minutes;
  logic [1:0] alm_set_mode;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;
  logic       led;

  modport master (
    output hours, minutes, seconds, chime_in, alm_on,
           set_alm, inc, snooze, stop,
    input  alm_hours, alm_minutes, alm_set_mode,
           ringing, snoozing, buzzer, led
  );

  modport slave (
    input  hours, minutes, seconds, chime_in, alm_on,
           set_alm, inc, snooze, stop,
    output alm_hours, alm_minutes, alm_set_mode,
           ringing, snoozing, buzzer, led
  );

endinterface

// File: rtl/alarm_time_reg.sv
// -----------------------------------------------------------------------------
// alarm_time_reg
// Holds the user-set alarm time and the edit mode. set_alm steps the edit mode
// NONE -> HOUR -> MIN -> NONE; inc bumps the field selected by the current
// mode with wrap (23 -> 0 for hours, 59 -> 0 for minutes).
//   clk_1Hz       : 1 Hz timing clock
//   rst           : asynchronous active-high reset
//   i_set_alm     : set-mode step pulse (already gated by the caller)
//   i_inc         : increment pulse
//   o_alm_hours   : stored alarm hour
//   o_alm_minutes : stored alarm minute
//   o_set_mode    : current edit mode
// -----------------------------------------------------------------------------
module alarm_time_reg
  import alarm_pkg::*;
(
  input  logic       clk_1Hz,
  input  logic       rst,
  input  logic       i_set_alm,
  input  logic       i_inc,
  output logic [7:0] o_alm_hours,
  output logic [7:0] o_alm_minutes,
  output logic [1:0] o_set_mode
);

  set_mode_e  r_mode;
  logic [7:0] r_hours;
  logic [7:0] r_minutes;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      r_mode    <= SET_NONE;
      r_hours   <= 8'd0;
      r_minutes <= 8'd0;
    end else begin
      // inc acts on the mode in force before this edge, so a simultaneous
      // set_alm does not redirect it.
      if (i_inc && (r_mode == SET_HOUR)) r_hours   <= wrap_inc(r_hours, HOUR_MAX);
      if (i_inc && (r_mode == SET_MIN))  r_minutes <= wrap_inc(r_minutes, MIN_MAX);
      if (i_set_alm)                     r_mode    <= next_set_mode(r_mode);
    end
  end

  assign o_alm_hours   = r_hours;
  assign o_alm_minutes = r_minutes;
  assign o_set_mode    = r_mode;

endmodule

// File: rtl/alarm_scheduler.sv
// -----------------------------------------------------------------------------
// alarm_scheduler
// Single wake-up alarm beside the 24-hour clock core. Compares the running
// time against the stored alarm time, sequences IDLE / RING / SNOOZE, and
// arbitrates the shared buzzer and LED between the alarm and the hourly chime.
// One clock cycle is one second.
//   clk_1Hz : 1 Hz timing clock
//   rst     : asynchronous active-high reset
//   io_bus  : alarm_scheduler_if.slave (time, buttons, alarm outputs)
// Parameters: RING_SECS (1..63), SNOOZE_MIN (1..15), MAX_SNOOZE (1..7).
// Macro ALARM_SNOOZE_EN: when defined, builds the SNOOZE state and its
// counters; when undefined, snooze is ignored and snoozing is tied low.
// -----------------------------------------------------------------------------
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS  = 30,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  alarm_scheduler_if.slave io_bus
);

  localparam logic [5:0] RING_LOAD = 6'(RING_SECS);

  // ---------------------------------------------------------------------------
  // Stored alarm time and edit mode
  // ---------------------------------------------------------------------------
  logic [7:0]   w_alm_hours;
  logic [7:0]   w_alm_minutes;
  logic [1:0]   w_set_mode;
  logic         w_set_alm;

  alarm_state_e r_state;
  alarm_state_e w_next_state;

  // Editing the alarm is only allowed while nothing is sounding.
  assign w_set_alm = io_bus.set_alm & (r_state == IDLE);

  alarm_time_reg u_time_reg (
    .clk_1Hz       (clk_1Hz),
    .rst           (rst),
    .i_set_alm     (w_set_alm),
    .i_inc         (io_bus.inc),
    .o_alm_hours   (w_alm_hours),
    .o_alm_minutes (w_alm_minutes),
    .o_set_mode    (w_set_mode)
  );

  // ---------------------------------------------------------------------------
  // Match detection: sampled at the hh:mm:00 edge, acted on one edge later
  // ---------------------------------------------------------------------------
  logic w_match;
  logic r_match;

  assign w_match = io_bus.alm_on
                 && (w_set_mode == SET_NONE)
                 && (r_state == IDLE)
                 && (io_bus.hours   == w_alm_hours)
                 && (io_bus.minutes == w_alm_minutes)
                 && (io_bus.seconds == 8'd0);

  // ---------------------------------------------------------------------------
  // Counters and phase
  // ---------------------------------------------------------------------------
  logic [5:0] r_ring_cnt;
  logic [5:0] w_ring_cnt_nx;
  logic       r_phase;
  logic       w_phase_nx;

`ifdef ALARM_SNOOZE_EN
  localparam logic [9:0] SNZ_LOAD     = 10'(SNOOZE_MIN * 60);
  localparam logic [2:0] SNOOZE_LIMIT = 3'(MAX_SNOOZE);

  logic [9:0] r_snz_cnt;
  logic [9:0] w_snz_cnt_nx;
  logic [2:0] r_snooze_cnt;
  logic [2:0] w_snooze_cnt_nx;
`else
  // Snooze hardware is not built; the button and its sizing parameters have
  // no load in this configuration.
  logic w_unused_snooze;
  assign w_unused_snooze = io_bus.snooze ^ (SNOOZE_MIN != 0) ^ (MAX_SNOOZE != 0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_ring_cnt_nx = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_nx    = r_snz_cnt;
    w_snooze_cnt_nx = r_snooze_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (r_match) begin
          w_next_state  = RING;
          w_ring_cnt_nx = RING_LOAD;
`ifdef ALARM_SNOOZE_EN
          w_snooze_cnt_nx = 3'd0;
`endif
        end
      end

      RING: begin
        // Priority: stop, then an allowed snooze, then the timeout count.
        if (io_bus.stop) begin
          w_next_state = IDLE;
        end
`ifdef ALARM_SNOOZE_EN
        else if (io_bus.snooze && (r_snooze_cnt < SNOOZE_LIMIT)) begin
          w_next_state    = SNOOZE;
          w_snz_cnt_nx    = SNZ_LOAD;
          w_snooze_cnt_nx = r_snooze_cnt + 3'd1;
        end
`endif
        else if (r_ring_cnt <= 6'd1) begin
          w_next_state = IDLE;
        end else begin
          w_ring_cnt_nx = r_ring_cnt - 6'd1;
        end
      end

`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (io_bus.stop) begin
          w_next_state = IDLE;
        end else if (r_snz_cnt <= 10'd1) begin
          // Snooze count is kept so the per-event limit spans re-rings.
          w_next_state  = RING;
          w_ring_cnt_nx = RING_LOAD;
        end else begin
          w_snz_cnt_nx = r_snz_cnt - 10'd1;
        end
      end
`endif

      default: w_next_state = IDLE;
    endcase

    // Disabling the alarm overrides every other event.
    if (!io_bus.alm_on) w_next_state = IDLE;

    // Phase restarts high on every RING entry and toggles while ringing.
    w_phase_nx = r_phase;
    if (w_next_state == RING) w_phase_nx = (r_state == RING) ? ~r_phase : 1'b1;
  end

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  logic r_ringing;
  logic r_buzzer;
  logic r_led;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_match    <= 1'b0;
      r_ring_cnt <= 6'd0;
      r_phase    <= 1'b0;
      r_ringing  <= 1'b0;
      r_buzzer   <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_match    <= w_match;
      r_ring_cnt <= w_ring_cnt_nx;
      r_phase    <= w_phase_nx;
      // Outputs are computed from the next state so they line up with r_state.
      r_ringing  <= (w_next_state == RING);
      r_buzzer   <= (w_next_state == RING) & w_phase_nx;
      // Alarm phase owns the LED while ringing; otherwise snooze or chime.
      r_led      <= (w_next_state == RING) ? w_phase_nx
                                           : ((w_next_state == SNOOZE) | io_bus.chime_in);
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic r_snoozing;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      r_snz_cnt    <= 10'd0;
      r_snooze_cnt <= 3'd0;
      r_snoozing   <= 1'b0;
    end else begin
      r_snz_cnt    <= w_snz_cnt_nx;
      r_snooze_cnt <= w_snooze_cnt_nx;
      r_snoozing   <= (w_next_state == SNOOZE);
    end
  end

  assign io_bus.snoozing = r_snoozing;
`else
  assign io_bus.snoozing = 1'b0;
`endif

  assign io_bus.alm_hours    = w_alm_hours;
  assign io_bus.alm_minutes  = w_alm_minutes;
  assign io_bus.alm_set_mode = w_set_mode;
  assign io_bus.ringing      = r_ringing;
  assign io_bus.buzzer       = r_buzzer;
  assign io_bus.led          = r_led;

endmodule

// File: tb/tb_alarm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alarm_scheduler
// Directed bench for alarm_scheduler: alarm-time editing from a vector table,
// then hand-written sequences for trigger latency, ring timeout, buzzer/LED
// arbitration, stop/snooze/alm_on priority and asynchronous reset.
// Snooze sequences follow ALARM_SNOOZE_EN so the bench suits either build.
// -----------------------------------------------------------------------------
module tb_alarm_scheduler;

  localparam int RING_SECS_TB  = 30;
  localparam int SNOOZE_CYC_TB = 5 * 60;

  logic clk_1Hz = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;

  alarm_scheduler_if io ();

  alarm_scheduler #(
    .RING_SECS  (30),
    .SNOOZE_MIN (5),
    .MAX_SNOOZE (3)
  ) dut (
    .clk_1Hz (clk_1Hz),
    .rst     (rst),
    .io_bus  (io.slave)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  typedef struct {
    logic       set_alm;
    logic       inc;
    int         reps;
    logic [1:0] mode;
    logic [7:0] hh;
    logic [7:0] mm;
  } set_vec_t;

  set_vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // One second: sample edge, then the clock core advances its time.
  task automatic cyc();
    @(posedge clk_1Hz);
    #1;
    if (io.seconds == 8'd59) begin
      io.seconds = 8'd0;
      if (io.minutes == 8'd59) begin
        io.minutes = 8'd0;
        io.hours   = (io.hours == 8'd23) ? 8'd0 : io.hours + 8'd1;
      end else begin
        io.minutes = io.minutes + 8'd1;
      end
    end else begin
      io.seconds = io.seconds + 8'd1;
    end
  endtask

  // Runs the clock through 06:30:00 so a 06:30 alarm starts ringing.
  task automatic trigger(input string tag);
    io.hours   = 8'd6;
    io.minutes = 8'd29;
    io.seconds = 8'd59;
    repeat (3) cyc();
    check({tag, " ringing"}, io.ringing, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst         = 1'b1;
    io.hours    = 8'd0;
    io.minutes  = 8'd0;
    io.seconds  = 8'd0;
    io.chime_in = 1'b0;
    io.alm_on   = 1'b0;
    io.set_alm  = 1'b0;
    io.inc      = 1'b0;
    io.snooze   = 1'b0;
    io.stop     = 1'b0;

    // Edit sequence 06:30 with both wraps exercised, then inc in mode 0.
    vecs[0] = '{set_alm: 1'b1, inc: 1'b0, reps: 1,  mode: 2'd1, hh: 8'd0,  mm: 8'd0};
    vecs[1] = '{set_alm: 1'b0, inc: 1'b1, reps: 23, mode: 2'd1, hh: 8'd23, mm: 8'd0};
    vecs[2] = '{set_alm: 1'b0, inc: 1'b1, reps: 1,  mode: 2'd1, hh: 8'd0,  mm: 8'd0};
    vecs[3] = '{set_alm: 1'b0, inc: 1'b1, reps: 6,  mode: 2'd1, hh: 8'd6,  mm: 8'd0};
    vecs[4] = '{set_alm: 1'b1, inc: 1'b0, reps: 1,  mode: 2'd2, hh: 8'd6,  mm: 8'd0};
    vecs[5] = '{set_alm: 1'b0, inc: 1'b1, reps: 59, mode: 2'd2, hh: 8'd6,  mm: 8'd59};
    vecs[6] = '{set_alm: 1'b0, inc: 1'b1, reps: 1,  mode: 2'd2, hh: 8'd6,  mm: 8'd0};
    vecs[7] = '{set_alm: 1'b0, inc: 1'b1, reps: 30, mode: 2'd2, hh: 8'd6,  mm: 8'd30};
    vecs[8] = '{set_alm: 1'b1, inc: 1'b0, reps: 1,  mode: 2'd0, hh: 8'd6,  mm: 8'd30};
    vecs[9] = '{set_alm: 1'b0, inc: 1'b1, reps: 3,  mode: 2'd0, hh: 8'd6,  mm: 8'd30};

    // Reset values.
    repeat (2) @(posedge clk_1Hz);
    #1;
    check("rst ringing",  io.ringing,      0);
    check("rst snoozing", io.snoozing,     0);
    check("rst buzzer",   io.buzzer,       0);
    check("rst led",      io.led,          0);
    check("rst hours",    io.alm_hours,    0);
    check("rst minutes",  io.alm_minutes,  0);
    check("rst mode",     io.alm_set_mode, 0);
    rst = 1'b0;

    // Alarm-time editing.
    for (int v = 0; v < 10; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        io.set_alm = vecs[v].set_alm;
        io.inc     = vecs[v].inc;
        cyc();
        io.set_alm = 1'b0;
        io.inc     = 1'b0;
      end
      check($sformatf("vec%0d mode", v),    io.alm_set_mode, vecs[v].mode);
      check($sformatf("vec%0d hours", v),   io.alm_hours,    vecs[v].hh);
      check($sformatf("vec%0d minutes", v), io.alm_minutes,  vecs[v].mm);
      check($sformatf("vec%0d ringing", v), io.ringing,      0);
    end

    // Chime in IDLE: LED follows with one cycle of delay.
    io.alm_on   = 1'b1;
    io.chime_in = 1'b1;
    check("chime pre-edge led", io.led, 0);
    cyc();
    check("chime idle led", io.led, 1);
    io.chime_in = 1'b0;
    cyc();
    check("chime idle led off", io.led, 0);

    // Trigger latency and unattended ring.
    io.hours   = 8'd6;
    io.minutes = 8'd29;
    io.seconds = 8'd59;
    cyc();
    check("pre-match ringing", io.ringing, 0);
    cyc();  // edge samples 06:30:00
    check("match edge ringing", io.ringing, 0);
    cyc();
    check("ring1 ringing", io.ringing, 1);
    check("ring1 buzzer",  io.buzzer,  1);
    check("ring1 led",     io.led,     1);
    for (int k = 2; k <= RING_SECS_TB + 1; k++) begin
      logic exp_ring;
      logic exp_buz;
      logic exp_led;
      if (k == 5)  io.set_alm  = 1'b1;
      if (k == 10) io.chime_in = 1'b1;
      cyc();
      io.set_alm = 1'b0;
      exp_ring = (k <= RING_SECS_TB);
      exp_buz  = exp_ring && (k % 2 == 1);
      exp_led  = exp_ring ? (k % 2 == 1) : 1'b1;
      check($sformatf("ring%0d ringing", k), io.ringing, exp_ring);
      check($sformatf("ring%0d buzzer", k),  io.buzzer,  exp_buz);
      check($sformatf("ring%0d led", k),     io.led,     exp_led);
    end
    check("set_alm ignored in ring", io.alm_set_mode, 0);
    io.chime_in = 1'b0;
    cyc();
    check("after timeout led", io.led, 0);
    check("after timeout buzzer", io.buzzer, 0);

    // Stop and snooze together: stop wins.
    trigger("stop+snz");
    io.stop   = 1'b1;
    io.snooze = 1'b1;
    cyc();
    io.stop   = 1'b0;
    io.snooze = 1'b0;
    check("stop+snz ringing",  io.ringing,  0);
    check("stop+snz snoozing", io.snoozing, 0);
    check("stop+snz buzzer",   io.buzzer,   0);
    repeat (2) cyc();
    check("stop+snz stays idle", io.ringing, 0);

    // alm_on low mid-ring forces IDLE on the next edge.
    trigger("alm_off");
    cyc();
    io.alm_on = 1'b0;
    cyc();
    check("alm_off ringing", io.ringing, 0);
    check("alm_off buzzer",  io.buzzer,  0);

    // No trigger while the alarm is disabled.
    io.hours   = 8'd6;
    io.minutes = 8'd29;
    io.seconds = 8'd59;
    repeat (3) cyc();
    check("disabled no trigger", io.ringing, 0);
    io.alm_on = 1'b1;

`ifdef ALARM_SNOOZE_EN
    trigger("snooze");
    for (int s = 1; s <= 3; s++) begin
      int n_snz;
      io.snooze = 1'b1;
      cyc();
      io.snooze = 1'b0;
      check($sformatf("snz%0d snoozing", s), io.snoozing, 1);
      check($sformatf("snz%0d ringing", s),  io.ringing,  0);
      check($sformatf("snz%0d led", s),      io.led,      1);
      check($sformatf("snz%0d buzzer", s),   io.buzzer,   0);
      n_snz = 1;
      for (int i = 0; i < SNOOZE_CYC_TB + 50; i++) begin
        cyc();
        if (!io.snoozing) break;
        n_snz++;
      end
      check($sformatf("snz%0d length", s),     n_snz,      SNOOZE_CYC_TB);
      check($sformatf("snz%0d re-ring", s),    io.ringing, 1);
      check($sformatf("snz%0d re-buzzer", s),  io.buzzer,  1);
    end
    io.snooze = 1'b1;
    cyc();
    io.snooze = 1'b0;
    check("snz4 ignored ringing",  io.ringing,  1);
    check("snz4 ignored snoozing", io.snoozing, 0);
    io.stop = 1'b1;
    cyc();
    io.stop = 1'b0;
    check("snz stop ringing", io.ringing, 0);

    // New alarm event allows snoozing again; then reset mid-snooze.
    trigger("rearm");
    io.snooze = 1'b1;
    cyc();
    io.snooze = 1'b0;
    check("rearm snoozing", io.snoozing, 1);
    cyc();
`else
    // Snooze is not built: the button has no effect while ringing.
    trigger("nosnz");
    io.snooze = 1'b1;
    cyc();
    io.snooze = 1'b0;
    check("nosnz ringing",  io.ringing,  1);
    check("nosnz snoozing", io.snoozing, 0);
    cyc();
    check("nosnz still ringing", io.ringing, 1);
`endif

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst ringing",  io.ringing,      0);
    check("arst snoozing", io.snoozing,     0);
    check("arst buzzer",   io.buzzer,       0);
    check("arst led",      io.led,          0);
    check("arst hours",    io.alm_hours,    0);
    check("arst minutes",  io.alm_minutes,  0);
    check("arst mode",     io.alm_set_mode, 0);
    io.alm_on = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    check("post-rst ringing", io.ringing, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
